// File: rtl/rcswitch_pkg.sv
// Shared field widths, status codes and state encodings for the
// rcswitch receive/match pair.
package rcswitch_pkg;

   localparam int ADDR_W = 40;
   localparam int CHAN_W = 40;
   localparam int STAT_W = 16;

   localparam logic [STAT_W-1:0] STAT_ON  = 16'h8E88;
   localparam logic [STAT_W-1:0] STAT_OFF = 16'h888E;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCUM  = 2'd1,
      ST_LOCKED = 2'd2
   } state_e;

   function automatic logic stat_valid(input logic [STAT_W-1:0] s);
      return (s == STAT_ON) || (s == STAT_OFF);
   endfunction

endpackage

// File: rtl/rcswitch_match.sv
// Qualifies decoded frames for one device and commits ON/OFF after
// REPEAT identical frames inside the timeout window.
module rcswitch_match
   import rcswitch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] ADDR    = 40'h8888888888,
   parameter logic [CHAN_W-1:0] CHAN    = 40'h888E8E8E8E,
   parameter int unsigned       REPEAT  = 2,
   parameter int unsigned       TIMEOUT = 100000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ready,
   input  logic [ADDR_W-1:0] addr,
   input  logic [CHAN_W-1:0] chan,
   input  logic [STAT_W-1:0] stat,
   output logic              sw,
   output logic              upd,
   output logic              rej,
   output logic [3:0]        cnt
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT);
   localparam logic [3:0]    RPT    = 4'(REPEAT);

   state_e              state_q, state_d;
   logic                ready_q;
   logic [STAT_W-1:0]   last_q, last_d;
   logic [TW-1:0]       timer_q, timer_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                sw_q, sw_d;
   logic                upd_q, upd_d;
   logic                rej_q, rej_d;
   logic                ev;
   logic                hit;
   logic                commit;

   assign ev  = ready & ~ready_q;
   assign hit = ev && (addr == ADDR) && (chan == CHAN);

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      timer_d = timer_q;
      cnt_d   = cnt_q;
      sw_d    = sw_q;
      upd_d   = 1'b0;
      rej_d   = 1'b0;
      commit  = 1'b0;

      if (hit && !stat_valid(stat)) begin
         rej_d   = 1'b1;
         state_d = ST_IDLE;
         cnt_d   = 4'd0;
         timer_d = '0;
      end else if (hit) begin
         timer_d = '0;
         if (state_q != ST_IDLE && stat == last_q) begin
            // Repeats while LOCKED only refresh the window.
            if (state_q == ST_ACCUM) begin
               cnt_d  = cnt_q + 4'd1;
               commit = (cnt_d == RPT);
            end
         end else begin
            last_d  = stat;
            cnt_d   = 4'd1;
            state_d = ST_ACCUM;
            commit  = (RPT == 4'd1);
         end
      end else if (state_q != ST_IDLE) begin
         if (timer_q == T_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
            timer_d = '0;
         end else if (timer_q != T_MAX) begin
            timer_d = timer_q + 1'b1;
         end
      end

      if (commit) begin
         state_d = ST_LOCKED;
         sw_d    = (last_d == STAT_ON);
         upd_d   = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         ready_q <= 1'b0;
         last_q  <= '0;
         timer_q <= '0;
         cnt_q   <= 4'd0;
         sw_q    <= 1'b0;
         upd_q   <= 1'b0;
         rej_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= ready;
         last_q  <= last_d;
         timer_q <= timer_d;
         cnt_q   <= cnt_d;
         sw_q    <= sw_d;
         upd_q   <= upd_d;
         rej_q   <= rej_d;
      end
   end

   assign sw  = sw_q;
   assign upd = upd_q;
   assign rej = rej_q;
   assign cnt = cnt_q;

endmodule

// File: tb/tb_rcswitch_match.sv
// Randomized and directed check of rcswitch_match against a
// timestamp-based reference model.
module tb_rcswitch_match;
   import rcswitch_pkg::*;

   localparam logic [39:0] MA  = 40'h8888888888;
   localparam logic [39:0] MC  = 40'h888E8E8E8E;
   localparam int          RPT = 2;
   localparam int          TO  = 100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ready = 1'b0;
   logic [39:0] addr = MA;
   logic [39:0] chan = MC;
   logic [15:0] stat = 16'h0;
   logic        sw, upd, rej;
   logic [3:0]  cnt;

   rcswitch_match #(
      .ADDR(MA), .CHAN(MC), .REPEAT(RPT), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst), .ready(ready),
      .addr(addr), .chan(chan), .stat(stat),
      .sw(sw), .upd(upd), .rej(rej), .cnt(cnt)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   int upd_seen = 0;
   int rej_seen = 0;

   // Reference model: burst tracked by timestamp of last accepted frame.
   bit          m_prev, m_act, m_sw, m_upd, m_rej;
   int          m_cnt, m_t, cyc;
   logic [15:0] m_last;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h at %0t",
                    tag, got, exp, $time);
   endtask

   task automatic m_reset();
      m_prev = 0; m_act = 0; m_sw = 0; m_upd = 0; m_rej = 0;
      m_cnt = 0; m_t = 0; m_last = 16'h0;
   endtask

   task automatic m_edge();
      bit ev, in_win;
      cyc++;
      m_upd = 0;
      m_rej = 0;
      ev = ready && !m_prev;
      m_prev = ready;
      in_win = m_act && (cyc - m_t <= TO);
      if (ev && addr == MA && chan == MC) begin
         if (stat != STAT_ON && stat != STAT_OFF) begin
            m_rej = 1; m_act = 0; m_cnt = 0;
         end else if (in_win && stat == m_last) begin
            m_t = cyc;
            if (m_cnt < RPT) begin
               m_cnt++;
               if (m_cnt == RPT) begin
                  m_sw = (stat == STAT_ON); m_upd = 1;
               end
            end
         end else begin
            m_act = 1; m_last = stat; m_cnt = 1; m_t = cyc;
            if (RPT == 1) begin
               m_sw = (stat == STAT_ON); m_upd = 1;
            end
         end
      end else if (m_act && cyc - m_t >= TO) begin
         m_act = 0; m_cnt = 0;
      end
   endtask

   task automatic step(input logic r, input logic rs);
      logic [6:0] got, exp;
      ready = r;
      rst = rs;
      @(posedge clk);
      #1;
      if (!rs) m_reset();
      else m_edge();
      if (upd) upd_seen++;
      if (rej) rej_seen++;
      got = {sw, upd, rej, cnt};
      exp = {m_sw, m_upd, m_rej, m_cnt[3:0]};
      chk("out", {25'd0, got}, {25'd0, exp});
   endtask

   task automatic frame(input logic [15:0] s, input logic [39:0] a,
                        input int w, input int gap);
      addr = a;
      chan = MC;
      stat = s;
      repeat (w) step(1'b1, 1'b1);
      repeat (gap) step(1'b0, 1'b1);
   endtask

   initial begin
      logic [63:0] rnd;
      logic [39:0] a;
      logic [15:0] s;
      int          k, w, gap;
      m_reset();
      cyc = 0;
      #2;
      for (int i = 0; i < 8; i++) step(i[0], 1'b0);
      chk("rst_sw", {31'd0, sw}, 32'd0);
      chk("rst_cnt", {28'd0, cnt}, 32'd0);
      repeat (3) step(1'b0, 1'b1);

      upd_seen = 0;
      frame(STAT_ON, MA, 3, 17);
      chk("two_on_cnt1", {28'd0, cnt}, 32'd1);
      frame(STAT_ON, MA, 3, 17);
      chk("two_on_sw", {31'd0, sw}, 32'd1);
      chk("two_on_upd", upd_seen, 32'd1);
      frame(STAT_ON, MA, 3, 17);
      chk("third_on_cnt", {28'd0, cnt}, 32'd2);
      chk("third_on_upd", upd_seen, 32'd1);

      repeat (150) step(1'b0, 1'b1);
      upd_seen = 0;
      frame(STAT_ON, MA, 3, 150);
      frame(STAT_ON, MA, 3, 7);
      chk("timeout_cnt", {28'd0, cnt}, 32'd1);
      chk("timeout_upd", upd_seen, 32'd0);
      frame(STAT_ON, MA, 3, 7);
      chk("after_to_upd", upd_seen, 32'd1);
      chk("after_to_sw", {31'd0, sw}, 32'd1);

      repeat (150) step(1'b0, 1'b1);
      upd_seen = 0;
      frame(STAT_ON, MA, 3, 10);
      frame(STAT_ON, 40'h8888888880, 3, 10);
      chk("foreign_cnt", {28'd0, cnt}, 32'd1);
      frame(STAT_ON, MA, 3, 10);
      chk("foreign_upd", upd_seen, 32'd1);
      frame(STAT_OFF, MA, 3, 10);
      frame(STAT_OFF, MA, 3, 10);
      chk("off_sw", {31'd0, sw}, 32'd0);
      chk("off_upd", upd_seen, 32'd2);

      rej_seen = 0;
      frame(16'h8888, MA, 3, 10);
      chk("rej_seen", rej_seen, 32'd1);
      chk("rej_cnt", {28'd0, cnt}, 32'd0);
      chk("rej_sw", {31'd0, sw}, 32'd0);
      frame(STAT_ON, MA, 50, 10);
      chk("long_ready_cnt", {28'd0, cnt}, 32'd1);

      upd_seen = 0;
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      frame(STAT_ON, MA, 3, 10);
      chk("post_rst_cnt", {28'd0, cnt}, 32'd1);
      chk("post_rst_upd", upd_seen, 32'd0);

      // Second frame exactly on the expiry edge still counts.
      repeat (150) step(1'b0, 1'b1);
      upd_seen = 0;
      frame(STAT_OFF, MA, 1, TO - 1);
      frame(STAT_OFF, MA, 1, 3);
      chk("edge_in_upd", upd_seen, 32'd1);
      repeat (150) step(1'b0, 1'b1);
      frame(STAT_ON, MA, 1, TO);
      frame(STAT_ON, MA, 1, 3);
      chk("edge_out_cnt", {28'd0, cnt}, 32'd1);

      for (int i = 0; i < 300; i++) begin
         rnd = {$urandom(), $urandom()};
         a = ($urandom_range(0, 5) == 0) ? rnd[39:0] : MA;
         k = $urandom_range(0, 9);
         s = (k < 5) ? STAT_ON : (k < 9) ? STAT_OFF : rnd[55:40];
         w = $urandom_range(1, 4);
         k = $urandom_range(0, 3);
         gap = (k < 2) ? $urandom_range(1, 30) :
               (k == 2) ? $urandom_range(TO - 6, TO + 2) :
               $urandom_range(110, 180);
         if ($urandom_range(0, 40) == 0) begin
            step(1'b0, 1'b0);
            step(1'b0, 1'b0);
         end
         frame(s, a, w, gap);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
